// File: rtl/dii_packet_arbiter.sv
// Per-packet round-robin arbiter merging N DII flit streams onto one registered output.
// A granted requester keeps the port until its last flit has been accepted.
module dii_packet_arbiter #(
   parameter int N     = 3,
   parameter int FLITW = 16
) (
   input  logic                        clk,
   input  logic                        rstn,
   input  logic [N-1:0]                in_valid,
   input  logic [N-1:0]                in_last,
   input  logic [N*FLITW-1:0]          in_data,
   output logic [N-1:0]                in_ready,
   output logic                        out_valid,
   output logic                        out_last,
   output logic [FLITW-1:0]            out_data,
   input  logic                        out_ready,
   output logic [$clog2(N)-1:0]        grant_idx,
   output logic                        locked,
   output logic [15:0]                 pkt_count
);

   // state  | meaning
   // IDLE   | no packet in progress, round-robin selection active
   // LOCKED | packet in progress, only grant_idx may deliver flits

   localparam int GW = $clog2(N);

   typedef enum logic {IDLE, LOCKED} state_t;

   state_t           state, state_nxt;
   logic [GW-1:0]    last_grant;
   logic [GW-1:0]    sel;
   logic [GW-1:0]    cand;
   logic [GW-1:0]    acc_idx;
   logic             any_valid;
   logic             slot_free;
   logic             accept;
   logic             acc_last;
   logic [FLITW-1:0] acc_data;
   logic [N-1:0]     ready_int;

   assign slot_free = !out_valid || out_ready;
   assign locked    = (state == LOCKED);

   // Scan from the farthest candidate back to the nearest so the nearest valid one wins.
   always_comb begin
      sel       = '0;
      cand      = '0;
      any_valid = 1'b0;
      for (int k = N; k >= 1; k--) begin
         cand = GW'((int'(last_grant) + k) % N);
         if (in_valid[cand]) begin
            sel       = cand;
            any_valid = 1'b1;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      ready_int = '0;
      acc_idx   = (state == LOCKED) ? grant_idx : sel;
      if (slot_free) begin
         if (state == LOCKED)
            ready_int[grant_idx] = 1'b1;
         else if (any_valid)
            ready_int[sel] = 1'b1;
      end
      accept   = |(ready_int & in_valid);
      acc_last = in_last[acc_idx];
      acc_data = in_data[int'(acc_idx)*FLITW +: FLITW];
      if (accept) begin
         if (state == IDLE && !acc_last)
            state_nxt = LOCKED;
         else if (state == LOCKED && acc_last)
            state_nxt = IDLE;
      end
   end

   // Reset must silence the handshake at once, not just at the next edge.
   assign in_ready = ready_int & {N{rstn}};

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         out_valid  <= 1'b0;
         out_last   <= 1'b0;
         out_data   <= '0;
         grant_idx  <= '0;
         last_grant <= GW'(N-1);
         pkt_count  <= '0;
      end else begin
         if (accept) begin
            out_valid <= 1'b1;
            out_last  <= acc_last;
            out_data  <= acc_data;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
         if (accept && state == IDLE)
            grant_idx <= sel;
         if (accept && acc_last) begin
            last_grant <= acc_idx;
            pkt_count  <= pkt_count + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_dii_packet_arbiter.sv
// Directed bench for dii_packet_arbiter: ordering, packet lock, backpressure,
// fairness, counter wrap and asynchronous reset mid-packet.
module tb_dii_packet_arbiter;

   localparam int N     = 3;
   localparam int FLITW = 16;

   logic                 clk = 1'b0;
   logic                 rstn;
   logic [N-1:0]         in_valid;
   logic [N-1:0]         in_last;
   logic [N*FLITW-1:0]   in_data;
   logic [N-1:0]         in_ready;
   logic                 out_valid;
   logic                 out_last;
   logic [FLITW-1:0]     out_data;
   logic                 out_ready;
   logic [1:0]           grant_idx;
   logic                 locked;
   logic [15:0]          pkt_count;

   int total  = 0;
   int passed = 0;
   int failed = 0;

   dii_packet_arbiter #(.N(N), .FLITW(FLITW)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .in_valid  (in_valid),
      .in_last   (in_last),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_last  (out_last),
      .out_data  (out_data),
      .out_ready (out_ready),
      .grant_idx (grant_idx),
      .locked    (locked),
      .pkt_count (pkt_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic setp(input int i, input logic v, input logic l, input logic [15:0] d);
      in_valid[i]              = v;
      in_last[i]               = l;
      in_data[i*FLITW +: FLITW] = d;
   endtask

   int              fc [N];
   int              dut_cnt [N];
   int              exp_port;
   logic [15:0]     exp_data;
   logic [N-1:0]    one_hot;

   initial begin
      rstn      = 1'b0;
      in_valid  = '0;
      in_last   = '0;
      in_data   = '0;
      out_ready = 1'b1;

      // Reset, then three simultaneous single-flit packets
      setp(0, 1'b1, 1'b1, 16'h0A00);
      setp(1, 1'b1, 1'b1, 16'h0B01);
      setp(2, 1'b1, 1'b1, 16'h0C02);
      #1;
      chk("rst_in_ready", 32'(in_ready), 32'h0);
      chk("rst_out_valid", 32'(out_valid), 32'h0);
      chk("rst_out_data", 32'(out_data), 32'h0);
      chk("rst_locked", 32'(locked), 32'h0);
      chk("rst_pkt_count", 32'(pkt_count), 32'h0);
      chk("rst_grant_idx", 32'(grant_idx), 32'h0);
      @(negedge clk);
      rstn = 1'b1;
      #1;
      chk("s1_ready0", 32'(in_ready), 32'h1);
      tick();
      chk("s1_data0", 32'(out_data), 32'h0A00);
      chk("s1_valid0", 32'(out_valid), 32'h1);
      setp(0, 1'b0, 1'b0, 16'h0);
      #1;
      chk("s1_ready1", 32'(in_ready), 32'h2);
      tick();
      chk("s1_data1", 32'(out_data), 32'h0B01);
      chk("s1_gidx1", 32'(grant_idx), 32'h1);
      setp(1, 1'b0, 1'b0, 16'h0);
      #1;
      chk("s1_ready2", 32'(in_ready), 32'h4);
      tick();
      chk("s1_data2", 32'(out_data), 32'h0C02);
      chk("s1_pkt_count", 32'(pkt_count), 32'd3);
      setp(2, 1'b0, 1'b0, 16'h0);
      tick();
      chk("s1_drained", 32'(out_valid), 32'h0);

      // Packet lock: port 1 four-flit packet, port 0 requests during flit 2
      setp(1, 1'b1, 1'b0, 16'h1000);
      #1;
      chk("lk_ready_f0", 32'(in_ready), 32'h2);
      tick();
      chk("lk_data_f0", 32'(out_data), 32'h1000);
      setp(1, 1'b1, 1'b0, 16'h1001);
      #1;
      chk("lk_locked_f1", 32'(locked), 32'h1);
      tick();
      chk("lk_data_f1", 32'(out_data), 32'h1001);
      setp(1, 1'b1, 1'b0, 16'h1002);
      setp(0, 1'b1, 1'b1, 16'h0D00);
      #1;
      chk("lk_ready_f2", 32'(in_ready), 32'h2);
      chk("lk_locked_f2", 32'(locked), 32'h1);
      tick();
      chk("lk_data_f2", 32'(out_data), 32'h1002);
      setp(1, 1'b1, 1'b1, 16'h1003);
      #1;
      chk("lk_ready_f3", 32'(in_ready), 32'h2);
      chk("lk_locked_f3", 32'(locked), 32'h1);
      tick();
      chk("lk_data_f3", 32'(out_data), 32'h1003);
      chk("lk_last_f3", 32'(out_last), 32'h1);
      chk("lk_unlocked", 32'(locked), 32'h0);
      chk("lk_pkt_count", 32'(pkt_count), 32'd4);
      setp(1, 1'b0, 1'b0, 16'h0);
      #1;
      chk("lk_ready_p0", 32'(in_ready), 32'h1);
      tick();
      chk("lk_data_p0", 32'(out_data), 32'h0D00);
      chk("lk_pkt_count2", 32'(pkt_count), 32'd5);
      setp(0, 1'b0, 1'b0, 16'h0);
      tick();

      // Backpressure: port 2 three-flit packet, out_ready low for 5 cycles
      setp(2, 1'b1, 1'b0, 16'h2000);
      #1;
      chk("bp_ready_f0", 32'(in_ready), 32'h4);
      tick();
      chk("bp_data_f0", 32'(out_data), 32'h2000);
      setp(2, 1'b1, 1'b0, 16'h2001);
      out_ready = 1'b0;
      #1;
      chk("bp_ready_full", 32'(in_ready), 32'h0);
      for (int c = 0; c < 5; c++) begin
         tick();
         chk("bp_hold_data", 32'(out_data), 32'h2000);
         chk("bp_hold_valid", 32'(out_valid), 32'h1);
         chk("bp_hold_ready", 32'(in_ready), 32'h0);
      end
      out_ready = 1'b1;
      #1;
      chk("bp_ready_resume", 32'(in_ready), 32'h4);
      tick();
      chk("bp_data_f1", 32'(out_data), 32'h2001);
      setp(2, 1'b1, 1'b1, 16'h2002);
      tick();
      chk("bp_data_f2", 32'(out_data), 32'h2002);
      chk("bp_pkt_count", 32'(pkt_count), 32'd6);
      setp(2, 1'b0, 1'b0, 16'h0);
      tick();
      chk("bp_drained", 32'(out_valid), 32'h0);

      // Fairness: all ports send 2-flit packets continuously, 30 packets
      for (int i = 0; i < N; i++) begin
         fc[i]      = 0;
         dut_cnt[i] = 0;
      end
      for (int c = 0; c < 60; c++) begin
         exp_port = (c / 2) % N;
         for (int i = 0; i < N; i++)
            setp(i, 1'b1, fc[i][0], 16'h3000 | 16'(i << 8) | 16'(fc[i] & 8'hFF));
         exp_data = 16'h3000 | 16'(exp_port << 8) | 16'(fc[exp_port] & 8'hFF);
         one_hot  = 3'(1 << exp_port);
         #1;
         chk("fr_ready", 32'(in_ready), 32'(one_hot));
         for (int i = 0; i < N; i++)
            if (in_ready[i] && in_last[i]) dut_cnt[i]++;
         tick();
         chk("fr_data", 32'(out_data), 32'(exp_data));
         if (c % 2 == 0) begin
            chk("fr_gidx", 32'(grant_idx), 32'(exp_port));
            chk("fr_locked", 32'(locked), 32'h1);
         end
         fc[exp_port]++;
      end
      for (int i = 0; i < N; i++)
         chk("fr_port_pkts", 32'(dut_cnt[i]), 32'd10);
      chk("fr_pkt_count", 32'(pkt_count), 32'd36);
      in_valid = '0;
      in_last  = '0;
      tick();

      // Wrap: 65537 single-flit packets from a fresh reset
      rstn = 1'b0;
      #1;
      @(negedge clk);
      rstn = 1'b1;
      setp(0, 1'b1, 1'b1, 16'h7777);
      for (int k = 0; k < 65535; k++) @(posedge clk);
      #1;
      chk("wr_ffff", 32'(pkt_count), 32'hFFFF);
      tick();
      chk("wr_zero", 32'(pkt_count), 32'h0000);
      tick();
      chk("wr_one", 32'(pkt_count), 32'h0001);
      setp(0, 1'b0, 1'b0, 16'h0);
      tick();

      // Async reset during flit 2 of a 3-flit packet
      setp(1, 1'b1, 1'b0, 16'h4000);
      #1;
      chk("ar_ready_f0", 32'(in_ready), 32'h2);
      tick();
      setp(1, 1'b1, 1'b0, 16'h4001);
      tick();
      chk("ar_data_f1", 32'(out_data), 32'h4001);
      chk("ar_locked", 32'(locked), 32'h1);
      setp(1, 1'b1, 1'b1, 16'h4002);
      #2;
      rstn = 1'b0;
      #1;
      chk("ar_out_valid", 32'(out_valid), 32'h0);
      chk("ar_locked_clr", 32'(locked), 32'h0);
      chk("ar_in_ready", 32'(in_ready), 32'h0);
      chk("ar_pkt_count", 32'(pkt_count), 32'h0);
      setp(0, 1'b1, 1'b1, 16'h5000);
      setp(1, 1'b1, 1'b1, 16'h5101);
      setp(2, 1'b1, 1'b1, 16'h5202);
      @(negedge clk);
      rstn = 1'b1;
      #1;
      chk("ar_ready_after", 32'(in_ready), 32'h1);
      tick();
      chk("ar_data_after", 32'(out_data), 32'h5000);
      chk("ar_gidx_after", 32'(grant_idx), 32'h0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
